dbus_mem_responder: RTL and testbench

- Data-memory responder: the far end of the memory stage's dbus load/store requests.
- Accepts one request at a time.
- Models a configurable access latency.
- Performs byte-strobed writes into an internal 64-bit-wide RAM.
- Returns the full aligned 64-bit word. The CPU side does lane extraction and sign/zero extension using msize and mem_unsigned.
- Used as the memory model in core-level simulation and as the behavioural target for later cache work.

---
 rtl/dbus_mem_responder_if.sv | 39 +++
 rtl/dbus_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_dbus_mem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dbus_mem_responder_if.sv
// Bus between the memory stage (master) and the data-memory responder (slave).
// The master holds a request until it sees resp_data_ok. The responder answers
// with a one-cycle pulse of resp_addr_ok and resp_data_ok.
interface dbus_mem_responder_if;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;

    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [63:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output req_size,
        output req_strobe,
        output req_data,
        input  resp_addr_ok,
        input  resp_data_ok,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_size,
        input  req_strobe,
        input  req_data,
        output resp_addr_ok,
        output resp_data_ok,
        output resp_data,
        output resp_err
    );
endinterface

// File: rtl/dbus_mem_responder.sv
// Data-memory responder for dbus load/store requests.
// It accepts one request at a time and waits LATENCY cycles. It then answers
// with a one-cycle pulse. Writes are byte-strobed into a 64-bit-wide RAM.
// Reads return the whole aligned doubleword. The requester performs lane
// extraction and sign or zero extension itself.
module dbus_mem_responder #(
    parameter int unsigned LATENCY    = 2,   // wait cycles between accept and response, 0..15
    parameter int unsigned DEPTH_LOG2 = 12   // log2 of RAM depth in 64-bit words
) (
    input  logic                 clk,
    input  logic                 resetn,
    dbus_mem_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2 + 3;   // byte-address bits that matter
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // FSM state and wait counter
    state_t                 state_q;
    logic [3:0]             cnt_q;

    // Request fields latched at acceptance
    logic [AW-1:0]          addr_q;
    logic [2:0]             size_q;
    logic [7:0]             strobe_q;
    logic [63:0]            data_q;

    // Registered outputs
    logic                   addr_ok_q;
    logic                   data_ok_q;
    logic [63:0]            rdata_q;
    logic                   err_q;

    // Backing store. Reset leaves it untouched.
    logic [63:0]            mem_q [DEPTH];

    // The access performed on the edge that enters RESP
    logic [AW-1:0]          acc_addr_d;
    logic [2:0]             acc_size_d;
    logic [7:0]             acc_strobe_d;
    logic [63:0]            acc_data_d;
    logic                   enter_resp_d;
    logic [DEPTH_LOG2-1:0]  acc_idx;
    logic                   acc_err;
    logic                   acc_write;

    // The address bits above the RAM index wrap away and are never used
    logic                   addr_hi_unused;
    assign addr_hi_unused = ^bus.req_addr[63:AW];

    // Returns 1 when the size is illegal or the address is not size-aligned
    function automatic logic access_err(input logic [2:0] lo, input logic [2:0] size);
        logic err;
        case (size)
            3'd0:    err = 1'b0;
            3'd1:    err = (lo[0]   != 1'b0);
            3'd2:    err = (lo[1:0] != 2'b00);
            3'd3:    err = (lo      != 3'b000);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Selects the fields of the access. With LATENCY=0 the RESP-entry edge is
    // also the accept edge, so the live bus fields are used in IDLE.
    // NOTE: every signal gets a default before the case so that no path leaves
    // a value unassigned, which would infer a latch.
    always_comb begin
        acc_addr_d   = addr_q;
        acc_size_d   = size_q;
        acc_strobe_d = strobe_q;
        acc_data_d   = data_q;
        enter_resp_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                acc_addr_d   = bus.req_addr[AW-1:0];
                acc_size_d   = bus.req_size;
                acc_strobe_d = bus.req_strobe;
                acc_data_d   = bus.req_data;
                enter_resp_d = bus.req_valid && (LATENCY == 0);
            end
            S_WAIT:  enter_resp_d = (cnt_q == 4'd1);
            default: enter_resp_d = 1'b0;
        endcase
    end

    assign acc_idx   = acc_addr_d[AW-1:3];
    assign acc_err   = access_err(acc_addr_d[2:0], acc_size_d);
    // A reset that is asserted before the RESP-entry edge cancels the write
    assign acc_write = resetn && enter_resp_d && !acc_err && (acc_strobe_d != 8'h00);

    // FSM, request latch and registered response outputs
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            size_q    <= 3'd0;
            strobe_q  <= 8'h00;
            data_q    <= 64'h0;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 64'h0;
            err_q     <= 1'b0;
        end else begin
            // The response outputs are a single-cycle pulse by default
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 64'h0;
            err_q     <= 1'b0;

            if (enter_resp_d) begin
                addr_ok_q <= 1'b1;
                data_ok_q <= 1'b1;
                err_q     <= acc_err;
                if (!acc_err && (acc_strobe_d == 8'h00)) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr[AW-1:0];
                        size_q   <= bus.req_size;
                        strobe_q <= bus.req_strobe;
                        data_q   <= bus.req_data;
                        cnt_q    <= LAT;
                        state_q  <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-strobed RAM write, committed on the edge that enters RESP
    // NOTE: the RAM array has no reset. A reset must not erase memory, and an
    // unreset array maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (acc_write && acc_strobe_d[i]) begin
                mem_q[acc_idx][8*i +: 8] <= acc_data_d[8*i +: 8];
            end
        end
    end

    assign bus.resp_addr_ok = addr_ok_q;
    assign bus.resp_data_ok = data_ok_q;
    assign bus.resp_data    = rdata_q;
    assign bus.resp_err     = err_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder. It drives four instances that differ
// only in LATENCY (2, 0, 5, 3). All four share the clock and the reset.
module tb_dbus_mem_responder;

    localparam int NU = 4;
    localparam int LATS [NU] = '{2, 0, 5, 3};

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Per-unit request drivers and response taps
    logic        rv   [NU];
    logic [63:0] ra   [NU];
    logic [2:0]  rsz  [NU];
    logic [7:0]  rstb [NU];
    logic [63:0] rdat_in [NU];
    logic        aok  [NU];
    logic        dok  [NU];
    logic [63:0] rdat [NU];
    logic        rerr [NU];

    dbus_mem_responder_if bus [NU] ();

    for (genvar g = 0; g < NU; g++) begin : g_glue
        assign bus[g].req_valid  = rv[g];
        assign bus[g].req_addr   = ra[g];
        assign bus[g].req_size   = rsz[g];
        assign bus[g].req_strobe = rstb[g];
        assign bus[g].req_data   = rdat_in[g];
        assign aok[g]  = bus[g].resp_addr_ok;
        assign dok[g]  = bus[g].resp_data_ok;
        assign rdat[g] = bus[g].resp_data;
        assign rerr[g] = bus[g].resp_err;
    end

    dbus_mem_responder #(.LATENCY(2), .DEPTH_LOG2(12)) u_lat2 (.clk(clk), .resetn(resetn), .bus(bus[0]));
    dbus_mem_responder #(.LATENCY(0), .DEPTH_LOG2(12)) u_lat0 (.clk(clk), .resetn(resetn), .bus(bus[1]));
    dbus_mem_responder #(.LATENCY(5), .DEPTH_LOG2(12)) u_lat5 (.clk(clk), .resetn(resetn), .bus(bus[2]));
    dbus_mem_responder #(.LATENCY(3), .DEPTH_LOG2(12)) u_lat3 (.clk(clk), .resetn(resetn), .bus(bus[3]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One transaction on unit u. The request starts just after a rising edge
    // (cycle T). lat is the cycle offset from T at which data_ok is seen, or
    // -1 on timeout. If hold is 0, req_valid is dropped after the accept edge.
    task automatic txn(input int u, input logic [63:0] addr, input logic [2:0] size,
                       input logic [7:0] strobe, input logic [63:0] data, input bit hold,
                       output int lat, output logic [63:0] d, output logic e, output logic a);
        @(posedge clk); #1;
        rv[u] = 1'b1; ra[u] = addr; rsz[u] = size; rstb[u] = strobe; rdat_in[u] = data;
        lat = -1; d = 'x; e = 1'bx; a = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (!hold) rv[u] = 1'b0;
            if (dok[u]) begin
                lat = k; d = rdat[u]; e = rerr[u]; a = aok[u];
                break;
            end
        end
        rv[u] = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int          lat;
        logic [63:0] d;
        logic        e, a;
        int          p0 [$];
        int          p5 [$];
        int          pulses;

        vecs[0]  = '{64'h80,   3'd3, 8'hFF, 64'h1122334455667788, 64'h0,                0};
        vecs[1]  = '{64'h80,   3'd3, 8'h00, 64'h0,                64'h1122334455667788, 0};
        vecs[2]  = '{64'h82,   3'd0, 8'h04, 64'h0000000000AB0000, 64'h0,                0};
        vecs[3]  = '{64'h80,   3'd3, 8'h00, 64'h0,                64'h1122334455AB7788, 0};
        vecs[4]  = '{64'h81,   3'd1, 8'h06, 64'h0000000000ABCD00, 64'h0,                1};
        vecs[5]  = '{64'h80,   3'd3, 8'h00, 64'h0,                64'h1122334455AB7788, 0};
        vecs[6]  = '{64'h8000, 3'd3, 8'hFF, 64'hDEADBEEF00000000, 64'h0,                0};
        vecs[7]  = '{64'h0,    3'd3, 8'h00, 64'h0,                64'hDEADBEEF00000000, 0};
        vecs[8]  = '{64'h84,   3'd2, 8'h00, 64'h0,                64'h1122334455AB7788, 0};
        vecs[9]  = '{64'h80,   3'd4, 8'h00, 64'h0,                64'h0,                1};
        vecs[10] = '{64'h86,   3'd2, 8'h00, 64'h0,                64'h0,                1};
        vecs[11] = '{64'h88,   3'd3, 8'hFF, 64'h0123456789ABCDEF, 64'h0,                0};
        vecs[12] = '{64'h8C,   3'd2, 8'hF0, 64'hCAFEF00D00000000, 64'h0,                0};
        vecs[13] = '{64'h88,   3'd3, 8'h00, 64'h0,                64'hCAFEF00D89ABCDEF, 0};

        for (int u = 0; u < NU; u++) begin
            rv[u] = 1'b0; ra[u] = '0; rsz[u] = '0; rstb[u] = '0; rdat_in[u] = '0;
        end
        resetn = 1'b0;
        #23;
        for (int u = 0; u < NU; u++) begin
            check($sformatf("reset_outputs_u%0d", u), {aok[u], dok[u], rerr[u], rdat[u]}, 64'h0);
        end
        #4 resetn = 1'b1;

        // Table-driven sequence on the LATENCY=2 unit: pulse at T+3
        for (int i = 0; i < 14; i++) begin
            txn(0, vecs[i].addr, vecs[i].size, vecs[i].strobe, vecs[i].data, 1'b1, lat, d, e, a);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("v%0d_err", i), {63'h0, e}, {63'h0, vecs[i].exp_err});
            check($sformatf("v%0d_addr_ok", i), {63'h0, a}, 64'h1);
        end

        // The initiator drops req_valid after one cycle. The transaction still completes.
        txn(0, 64'h80, 3'd3, 8'h00, 64'h0, 1'b0, lat, d, e, a);
        check("drop_valid_latency", 64'(lat), 64'd3);
        check("drop_valid_data", d, 64'h1122334455AB7788);

        // Latency sweep with req_valid held: LATENCY 0 and 5 run side by side
        @(posedge clk); #1;
        for (int u = 1; u <= 2; u++) begin
            rv[u] = 1'b1; ra[u] = 64'h10; rsz[u] = 3'd3; rstb[u] = 8'hFF; rdat_in[u] = 64'h5A5A;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (dok[1]) begin
                p0.push_back(c);
                if (p0.size() == 1) check("lat0_first_data_err", {rdat[1], rerr[1]} == 65'h0 ? 64'h0 : 64'h1, 64'h0);
            end
            if (dok[2]) begin
                p5.push_back(c);
                if (p5.size() == 1) check("lat5_first_data_err", {rdat[2], rerr[2]} == 65'h0 ? 64'h0 : 64'h1, 64'h0);
            end
        end
        rv[1] = 1'b0; rv[2] = 1'b0;
        check("lat0_pulse_count", 64'(p0.size()), 64'd10);
        check("lat5_pulse_count", 64'(p5.size()), 64'd3);
        if (p0.size() >= 3) begin
            check("lat0_first_pulse", 64'(p0[0]), 64'd1);
            check("lat0_spacing_a", 64'(p0[1] - p0[0]), 64'd2);
            check("lat0_spacing_b", 64'(p0[2] - p0[1]), 64'd2);
        end else begin
            check("lat0_pulses_seen", 64'(p0.size()), 64'd3);
        end
        if (p5.size() >= 2) begin
            check("lat5_first_pulse", 64'(p5[0]), 64'd6);
            check("lat5_spacing", 64'(p5[1] - p5[0]), 64'd7);
        end else begin
            check("lat5_pulses_seen", 64'(p5.size()), 64'd2);
        end
        repeat (10) @(posedge clk);

        // Reset mid-operation. Unit 3 (LATENCY=3) holds an old value at 0x40.
        txn(3, 64'h40, 3'd3, 8'hFF, 64'h5555AAAA5555AAAA, 1'b1, lat, d, e, a);
        check("u3_setup_latency", 64'(lat), 64'd4);
        @(posedge clk); #1;                 // cycle S: unit 0 read begins, pulse due at S+3
        rv[0] = 1'b1; ra[0] = 64'h80; rsz[0] = 3'd3; rstb[0] = 8'h00;
        @(posedge clk); #1;                 // cycle T: unit 3 write begins
        rv[3] = 1'b1; ra[3] = 64'h40; rsz[3] = 3'd3; rstb[3] = 8'hFF; rdat_in[3] = 64'h0123456789ABCDEF;
        @(posedge clk); #1;                 // T+1
        rv[0] = 1'b0; rv[3] = 1'b0;
        @(posedge clk); #1;                 // T+2
        check("pre_reset_u0_data_ok", {63'h0, dok[0]}, 64'h1);
        check("pre_reset_u0_data", rdat[0], 64'h1122334455AB7788);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_u0_outputs", {aok[0], dok[0], rerr[0], rdat[0]}, 64'h0);
        check("async_reset_u3_outputs", {aok[3], dok[3], rerr[3], rdat[3]}, 64'h0);
        @(posedge clk); #3 resetn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dok[0] || dok[3]) pulses++;
        end
        check("no_pulse_after_reset", 64'(pulses), 64'd0);
        txn(3, 64'h40, 3'd3, 8'h00, 64'h0, 1'b1, lat, d, e, a);
        check("u3_after_reset_latency", 64'(lat), 64'd4);
        check("u3_after_reset_old_value", d, 64'h5555AAAA5555AAAA);
        txn(0, 64'h80, 3'd3, 8'h00, 64'h0, 1'b1, lat, d, e, a);
        check("u0_ram_kept_over_reset", d, 64'h1122334455AB7788);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
